// File: rtl/lisa_debug_uart_if.sv
// Host-side bus bundle for the LISA debug UART: baud generator control, TX and RX handshakes.
// The DUT takes the slave view and the host takes the master view.
interface lisa_debug_uart_if;
    logic       brg_wr;
    logic [7:0] brg_d;
    logic       baud_set;
    logic [6:0] baud_div;
    logic       baud_ref;
    logic       tx_wr;
    logic [7:0] tx_d;
    logic       txd;
    logic       tx_buf_empty;
    logic       rxd;
    logic       rx_rd;
    logic [7:0] rx_d;
    logic       rx_avail;

    modport master (
        output brg_wr, brg_d, baud_set, baud_div, tx_wr, tx_d, rxd, rx_rd,
        input  baud_ref, txd, tx_buf_empty, rx_d, rx_avail
    );

    modport slave (
        input  brg_wr, brg_d, baud_set, baud_div, tx_wr, tx_d, rxd, rx_rd,
        output baud_ref, txd, tx_buf_empty, rx_d, rx_avail
    );
endinterface

// File: rtl/lisa_debug_uart.sv
// Debug 8N1 UART: programmable 16x baud-reference generator, buffered transmitter and
// oversampling receiver, all paced by the one-clock baud_ref tick.
module lisa_debug_uart #(
    parameter logic [6:0] DIV_RESET = 7'd81
) (
    input logic               clk,
    input logic               rst,
    lisa_debug_uart_if.slave  bus
);

    typedef enum logic [1:0] {TxIdle, TxWait, TxSend} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

    // Baud reference generator
    logic [6:0] div_q, div_d, cnt_q, cnt_d, brg_n;
    logic       tick_q, tick_d;
    logic       unused_brg_msb;

    assign unused_brg_msb = bus.brg_d[7];

    always_comb begin
        brg_n = bus.baud_set ? bus.baud_div : div_q;
        div_d = bus.brg_wr ? bus.brg_d[6:0] : div_q;
        if (cnt_q == 7'd0) begin
            cnt_d  = brg_n;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q - 7'd1;
            tick_d = 1'b0;
        end
    end

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic [9:0] tx_frame_q, tx_frame_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [3:0] tx_bcnt_q, tx_bcnt_d;
    logic       tx_end, tx_load;

    assign tx_end  = (tx_state_q == TxSend) && tick_q && (tx_tcnt_q == 4'd15) &&
                     (tx_bcnt_q == 4'd9);
    assign tx_load = tx_full_q && ((tx_state_q == TxIdle) || tx_end);

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TxIdle:  if (tx_full_q) tx_state_d = TxWait;
            TxWait:  if (tick_q) tx_state_d = TxSend;
            TxSend:  if (tx_end && !tx_full_q) tx_state_d = TxIdle;
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        tx_frame_d = tx_frame_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        if (tx_load) begin
            tx_full_d  = 1'b0;
            tx_frame_d = {1'b1, tx_buf_q, 1'b0};
            tx_tcnt_d  = 4'd0;
            tx_bcnt_d  = 4'd0;
        end else if ((tx_state_q == TxSend) && tick_q) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                tx_frame_d = {1'b1, tx_frame_q[9:1]};
                tx_bcnt_d  = tx_bcnt_q + 4'd1;
            end
        end
        // A full buffer blocks writes, so this never collides with tx_load.
        if (bus.tx_wr && !tx_full_q) begin
            tx_buf_d  = bus.tx_d;
            tx_full_d = 1'b1;
        end
    end

    always_comb begin
        bus.txd          = (tx_state_q == TxSend) ? tx_frame_q[0] : 1'b1;
        bus.tx_buf_empty = ~tx_full_q;
        bus.baud_ref     = tick_q;
    end

    // Receiver
    rx_state_e  rx_state_q, rx_state_d;
    logic       sync1_q, sync2_q;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bcnt_q, rx_bcnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_avail_q, rx_avail_d;
    logic       rx_done;

    assign rx_done = (rx_state_q == RxStop) && tick_q && (rx_tcnt_q == 4'd15) && sync2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        if (tick_q) begin
            case (rx_state_q)
                RxIdle:     if (!sync2_q) rx_state_d = RxStart;
                RxStart:    if (rx_tcnt_q == 4'd7) rx_state_d = sync2_q ? RxIdle : RxData;
                RxData:     if (rx_tcnt_q == 4'd15 && rx_bcnt_q == 3'd7) rx_state_d = RxStop;
                RxStop:     if (rx_tcnt_q == 4'd15) rx_state_d = sync2_q ? RxIdle : RxWaitHigh;
                RxWaitHigh: if (sync2_q) rx_state_d = RxIdle;
                default:    rx_state_d = RxIdle;
            endcase
        end
    end

    always_comb begin
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        if (tick_q) begin
            // Tick count restarts on every state change so each phase measures from its entry.
            rx_tcnt_d = (rx_state_d != rx_state_q) ? 4'd0 : rx_tcnt_q + 4'd1;
            if (rx_state_q == RxStart) rx_bcnt_d = 3'd0;
            if ((rx_state_q == RxData) && (rx_tcnt_q == 4'd15)) begin
                rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                rx_bcnt_d  = rx_bcnt_q + 3'd1;
            end
        end
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_avail_d = rx_done ? 1'b1 : (bus.rx_rd ? 1'b0 : rx_avail_q);
    end

    always_comb begin
        bus.rx_d     = rx_data_q;
        bus.rx_avail = rx_avail_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_RESET;
            cnt_q      <= 7'd0;
            tick_q     <= 1'b0;
            tx_state_q <= TxIdle;
            tx_buf_q   <= 8'd0;
            tx_full_q  <= 1'b0;
            tx_frame_q <= 10'h3ff;
            tx_tcnt_q  <= 4'd0;
            tx_bcnt_q  <= 4'd0;
            rx_state_q <= RxIdle;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_tcnt_q  <= 4'd0;
            rx_bcnt_q  <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_avail_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            tx_state_q <= tx_state_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_frame_q <= tx_frame_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            rx_state_q <= rx_state_d;
            sync1_q    <= bus.rxd;
            sync2_q    <= sync1_q;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
        end
    end

endmodule

// File: tb/tb_lisa_debug_uart.sv
// Directed bench for lisa_debug_uart: baud generator periods, loopback TX/RX, buffer
// handling, false starts, framing errors, overrun and mid-frame reset.
module tb_lisa_debug_uart;

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic rx_drv;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    lisa_debug_uart_if u_if ();

    assign u_if.rxd = loop_en ? u_if.txd : rx_drv;

    lisa_debug_uart #(.DIV_RESET(7'd81)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of clocks between two consecutive baud_ref pulses (0 on timeout).
    task automatic measure_period(output int n);
        int w = 0;
        while (!u_if.baud_ref && w < 300) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        if (u_if.baud_ref) begin
            do begin
                @(negedge clk);
                n++;
            end while (!u_if.baud_ref && n < 300);
        end
    endtask

    task automatic wait_avail(input int lim, output bit ok);
        int w = 0;
        while (!u_if.rx_avail && w < lim) begin
            @(negedge clk);
            w++;
        end
        ok = u_if.rx_avail;
    endtask

    task automatic wait_txd_low(input int lim, output bit ok);
        int w = 0;
        while (u_if.txd && w < lim) begin
            @(negedge clk);
            w++;
        end
        ok = !u_if.txd;
    endtask

    task automatic tx_write(input logic [7:0] d);
        u_if.tx_wr = 1'b1;
        u_if.tx_d  = d;
        @(negedge clk);
        u_if.tx_wr = 1'b0;
    endtask

    task automatic rx_read();
        u_if.rx_rd = 1'b1;
        @(negedge clk);
        u_if.rx_rd = 1'b0;
    endtask

    // Drives one frame on rxd with 64 clocks per bit (16 ticks at a 4-clock tick).
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_drv = 1'b0;
        cycles(64);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cycles(64);
        end
        rx_drv = stop;
        cycles(64);
        rx_drv = 1'b1;
    endtask

    initial begin
        int  n;
        int  t0;
        bit  ok;

        rst           = 1'b1;
        loop_en       = 1'b1;
        rx_drv        = 1'b1;
        u_if.brg_wr   = 1'b0;
        u_if.brg_d    = 8'h00;
        u_if.baud_set = 1'b1;
        u_if.baud_div = 7'd81;
        u_if.tx_wr    = 1'b0;
        u_if.tx_d     = 8'h00;
        u_if.rx_rd    = 1'b0;
        cycles(3);
        check("rst_baud_ref", {31'd0, u_if.baud_ref}, 32'd0);
        check("rst_txd", {31'd0, u_if.txd}, 32'd1);
        check("rst_tx_buf_empty", {31'd0, u_if.tx_buf_empty}, 32'd1);
        check("rst_rx_avail", {31'd0, u_if.rx_avail}, 32'd0);
        check("rst_rx_d", {24'd0, u_if.rx_d}, 32'h00);
        rst = 1'b0;

        measure_period(n);
        check("period_div81", n, 32'd82);
        measure_period(n);
        check("period_div81_again", n, 32'd82);

        // Loopback 0xA5 at tick period 82
        tx_write(8'hA5);
        check("tx_buf_full_after_wr", {31'd0, u_if.tx_buf_empty}, 32'd0);
        @(negedge clk);
        check("tx_buf_empty_after_move", {31'd0, u_if.tx_buf_empty}, 32'd1);
        wait_txd_low(200, ok);
        check("a5_start_seen", {31'd0, ok}, 32'd1);
        n = 0;
        while (!u_if.txd && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("a5_start_len", n, 32'd1312);
        wait_avail(20000, ok);
        check("a5_avail", {31'd0, ok}, 32'd1);
        check("a5_data", {24'd0, u_if.rx_d}, 32'hA5);
        rx_read();
        check("a5_rd_clears", {31'd0, u_if.rx_avail}, 32'd0);
        check("a5_rd_holds", {24'd0, u_if.rx_d}, 32'hA5);
        cycles(2000);

        // Buffered back-to-back frames at tick period 4
        u_if.baud_div = 7'd3;
        cycles(200);
        measure_period(n);
        check("period_div3", n, 32'd4);
        tx_write(8'h55);
        check("b2b_full_1", {31'd0, u_if.tx_buf_empty}, 32'd0);
        @(negedge clk);
        check("b2b_moved_1", {31'd0, u_if.tx_buf_empty}, 32'd1);
        tx_write(8'h00);
        check("b2b_full_2", {31'd0, u_if.tx_buf_empty}, 32'd0);
        tx_write(8'hFF);
        check("b2b_still_full", {31'd0, u_if.tx_buf_empty}, 32'd0);
        wait_avail(2000, ok);
        t0 = cyc;
        check("b2b_avail_1", {31'd0, ok}, 32'd1);
        check("b2b_data_1", {24'd0, u_if.rx_d}, 32'h55);
        rx_read();
        wait_avail(2000, ok);
        check("b2b_avail_2", {31'd0, ok}, 32'd1);
        check("b2b_data_2", {24'd0, u_if.rx_d}, 32'h00);
        check("b2b_spacing", cyc - t0, 32'd640);
        rx_read();
        cycles(1500);
        check("third_write_dropped", {31'd0, u_if.rx_avail}, 32'd0);

        // Driven rxd: short glitch, framing error, recovery, overrun
        loop_en = 1'b0;
        cycles(50);
        rx_drv = 1'b0;
        cycles(16);
        rx_drv = 1'b1;
        cycles(800);
        check("glitch_no_byte", {31'd0, u_if.rx_avail}, 32'd0);
        send_frame(8'h3C, 1'b0);
        cycles(200);
        check("framing_err_no_byte", {31'd0, u_if.rx_avail}, 32'd0);
        send_frame(8'h81, 1'b1);
        cycles(20);
        check("good_after_ferr_avail", {31'd0, u_if.rx_avail}, 32'd1);
        check("good_after_ferr_data", {24'd0, u_if.rx_d}, 32'h81);
        rx_read();
        cycles(100);
        send_frame(8'h12, 1'b1);
        cycles(64);
        send_frame(8'h34, 1'b1);
        cycles(20);
        check("overrun_avail", {31'd0, u_if.rx_avail}, 32'd1);
        check("overrun_data", {24'd0, u_if.rx_d}, 32'h34);
        rx_read();

        // Divisor register path
        u_if.baud_set = 1'b0;
        cycles(200);
        measure_period(n);
        check("period_div_reset", n, 32'd82);
        u_if.brg_wr = 1'b1;
        u_if.brg_d  = 8'h03;
        @(negedge clk);
        u_if.brg_wr = 1'b0;
        cycles(200);
        measure_period(n);
        check("period_div_reg3", n, 32'd4);

        // Reset in the middle of a frame, then a clean frame afterwards
        loop_en = 1'b1;
        cycles(100);
        tx_write(8'h00);
        wait_txd_low(100, ok);
        check("rst_mid_start_seen", {31'd0, ok}, 32'd1);
        cycles(100);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", {31'd0, u_if.txd}, 32'd1);
        check("rst_mid_buf_empty", {31'd0, u_if.tx_buf_empty}, 32'd1);
        check("rst_mid_rx_d", {24'd0, u_if.rx_d}, 32'h00);
        rst = 1'b0;
        cycles(20);
        u_if.baud_set = 1'b1;
        cycles(200);
        tx_write(8'h5A);
        wait_avail(2000, ok);
        check("post_rst_avail", {31'd0, ok}, 32'd1);
        check("post_rst_data", {24'd0, u_if.rx_d}, 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
